fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the processor core: holds the program counter, drives the instruction memory address, and registers the fetched 9-bit instruction for the decode stage directly downstream. It starts a program at the externally supplied `start_address` and redirects on taken branches from execute. It stalls on downstream back-pressure, detects the halt word, and raises the top-level `done`.

## Interface
- `PC_W`, 10, program counter and instruction-memory address width
- `INSTR_W`, 9, instruction width
- `HALT_WORD`, 9'h1FF, instruction encoding that ends the program
- `clock`  input  1  single clock; all state updates on its rising edge
- `start`  input  1  reset: synchronous, active-high; loads PC from `start_address`
- `start_address`  input  7  program entry point, zero-extended to `PC_W`
- `stall`  input  1  downstream cannot accept a new instruction this cycle
- `branch_taken`  input  1  execute stage redirects fetch this cycle
- `branch_target`  input  PC_W  absolute redirect address
- `imem_addr`  output  PC_W  instruction memory address (combinational read)
- `imem_data`  input  INSTR_W  instruction word at `imem_addr`, same cycle
- `instr`  output  INSTR_W  registered instruction to decode
- `instr_valid`  output  1  `instr` is a real, non-squashed instruction
- `pc_out`  output  PC_W  address `instr` was fetched from
- `done`  output  1  program has halted

## Operation
- States: RUN and HALTED.
- `imem_addr` = internal `pc` register, combinational.
- Priority each edge: `start` > `branch_taken` > `stall` > halt detect > normal fetch.
- `start`=1: `pc`<=`start_address` zero-extended, `instr`<=0, `instr_valid`<=0, `pc_out`<=0, `done`<=0, state<=RUN. This applies in any state and mid-program.
- RUN, `branch_taken`: `pc`<=`branch_target`, `instr_valid`<=0 (wrong-path word squashed), `instr`/`pc_out` hold. This applies even when `stall`=1.
- RUN, `stall`: `pc`, `instr`, `instr_valid`, `pc_out` all hold.
- RUN, `imem_data`==`HALT_WORD`: state<=HALTED, `done`<=1, `instr_valid`<=0, `pc` holds. The halt word is never issued to decode.
- RUN, normal: `instr`<=`imem_data`, `pc_out`<=`pc`, `instr_valid`<=1, `pc`<=`pc`+1 modulo 2^PC_W. 2^PC_W−1 wraps to 0.
- HALTED: all registers hold. `done` stays 1 and ignores `branch_taken`/`stall` until `start`.

## Timing
- Every output except `imem_addr` is registered.
- Reset values: `instr`=0, `instr_valid`=0, `pc_out`=0, `done`=0, `imem_addr`=`start_address`.
- First fetch: on the first edge with `start`=0, `instr`=mem[`start_address`] with `instr_valid`=1 (1-cycle latency).
- Branch penalty: 1 bubble. The edge after `branch_taken` shows `instr_valid`=0; the next edge shows mem[`branch_target`].
- `done` rises on the edge that samples `HALT_WORD` on `imem_data`, 1 cycle after the halt address is presented.
- `start` held high for multiple cycles keeps the block in reset. No fetch occurs while `start`=1.

## Configuration
- `FETCH_CYCLE_COUNT_EN` defined: adds output `cycle_count`, 16 bits.
  - Cleared by `start`.
  - Increments on every edge in RUN, including stall and bubble cycles.
  - Saturates at 16'hFFFF and freezes in HALTED.
- `FETCH_CYCLE_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Straight line: `start` high 1 cycle with `start_address`=7'd5, memory 5:9'h012, 6:9'h034, 7:9'h1FF -> `instr` 12h then 34h with `pc_out` 5,6; `done`=1 on the next edge; `instr_valid`=0 afterwards.
- Branch: at `pc`=8, pulse `branch_taken` with `branch_target`=10'd40 while `stall`=1 -> one cycle `instr_valid`=0, then `instr`=mem[40], `pc_out`=40.
- Stall: `stall` high 3 cycles during RUN -> `instr`/`pc_out`/`imem_addr` constant for 3 edges, resume at the next address with no word skipped.
- Wrap: `start_address`=0, branch to 10'h3FF holding a non-halt word -> `pc_out`=3FF, then `imem_addr`=0.
- Restart: `start` asserted mid-program and again after `done` -> all outputs return to reset values within 1 edge, and the program re-executes from the new `start_address`.
- With `FETCH_CYCLE_COUNT_EN`: the straight-line case ends with `cycle_count`=3, which stays constant while HALTED.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect/stall inputs, instruction memory port, decode outputs.
// FETCH_CYCLE_COUNT_EN adds the cycle_count signal to the bundle.
interface fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
);
    logic [6:0]         start_address;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    pc_out;
    logic               done;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0]        cycle_count;

    modport master (
        input  start_address, stall, branch_taken, branch_target, imem_data,
        output imem_addr, instr, instr_valid, pc_out, done, cycle_count
    );
    modport slave (
        output start_address, stall, branch_taken, branch_target, imem_data,
        input  imem_addr, instr, instr_valid, pc_out, done, cycle_count
    );
`else
    modport master (
        input  start_address, stall, branch_taken, branch_target, imem_data,
        output imem_addr, instr, instr_valid, pc_out, done
    );
    modport slave (
        output start_address, stall, branch_taken, branch_target, imem_data,
        input  imem_addr, instr, instr_valid, pc_out, done
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem address, registered instruction to decode.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating 16-bit RUN-cycle counter.
module fetch_unit #(
    parameter int               PC_W      = 10,
    parameter int               INSTR_W   = 9,
    parameter logic [INSTR_W-1:0] HALT_WORD = 9'h1FF
) (
    input  logic         clock,
    input  logic         start,
    fetch_unit_if.master bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [PC_W-1:0]    pcout_q, pcout_d;
    logic               done_q, done_d;

    logic [PC_W-1:0]    entry_pc;

    assign entry_pc = {{(PC_W-7){1'b0}}, bus.start_address};

    // Next-state: branch beats stall beats halt detect beats normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pcout_d = pcout_q;
        done_d  = done_q;
        if (state_q == RUN) begin
            if (bus.branch_taken) begin
                pc_d    = bus.branch_target;
                valid_d = 1'b0;
            end else if (bus.stall) begin
                pc_d = pc_q;
            end else if (bus.imem_data == HALT_WORD) begin
                state_d = HALTED;
                done_d  = 1'b1;
                valid_d = 1'b0;
            end else begin
                instr_d = bus.imem_data;
                pcout_d = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + PC_W'(1);
            end
        end
    end

    // State registers; start reloads the entry point.
    always_ff @(posedge clock) begin
        if (start) begin
            state_q <= RUN;
            pc_q    <= entry_pc;
            instr_q <= '0;
            valid_q <= 1'b0;
            pcout_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pcout_q <= pcout_d;
            done_q  <= done_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pcout_q;
    assign bus.done        = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts every RUN edge, saturating; frozen once halted.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == RUN && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register, cleared by start.
    always_ff @(posedge clock) begin
        if (start) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cycle_count = cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan steps, then random
// stimulus checked against a behavioural reference model.
module tb_fetch_unit;
    logic clock = 1'b0;
    logic start = 1'b0;

    fetch_unit_if #(.PC_W(10), .INSTR_W(9)) ifc ();

    fetch_unit dut (
        .clock (clock),
        .start (start),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    logic [8:0] mem [1024];

    always_comb ifc.imem_data = mem[ifc.imem_addr];

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic [9:0]  m_pc;
    logic [8:0]  m_instr;
    logic        m_valid;
    logic [9:0]  m_pcout;
    logic        m_done;
    logic        m_halted;
    int          m_cnt;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic st, input logic [6:0] sa,
                              input logic stl, input logic br,
                              input logic [9:0] tgt);
        if (st) begin
            m_pc = {3'b000, sa};
            m_instr = '0; m_valid = 0; m_pcout = '0;
            m_done = 0; m_halted = 0; m_cnt = 0;
        end else if (!m_halted) begin
            if (m_cnt < 65535) m_cnt++;
            if (br) begin
                m_pc = tgt;
                m_valid = 0;
            end else if (stl) begin
                // everything holds
            end else if (mem[m_pc] == 9'h1FF) begin
                m_halted = 1; m_done = 1; m_valid = 0;
            end else begin
                m_instr = mem[m_pc];
                m_pcout = m_pc;
                m_valid = 1;
                m_pc = 10'((int'(m_pc) + 1) % 1024);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  16'(ifc.imem_addr),   16'(m_pc));
        chk({tag, ".instr"}, 16'(ifc.instr),       16'(m_instr));
        chk({tag, ".valid"}, 16'(ifc.instr_valid), 16'(m_valid));
        chk({tag, ".pcout"}, 16'(ifc.pc_out),      16'(m_pcout));
        chk({tag, ".done"},  16'(ifc.done),        16'(m_done));
`ifdef FETCH_CYCLE_COUNT_EN
        chk({tag, ".cnt"},   ifc.cycle_count,      16'(m_cnt));
`endif
    endtask

    task automatic step(input string tag, input logic st, input logic [6:0] sa,
                        input logic stl, input logic br, input logic [9:0] tgt);
        @(negedge clock);
        start = st;
        ifc.start_address = sa;
        ifc.stall = stl;
        ifc.branch_taken = br;
        ifc.branch_target = tgt;
        @(posedge clock);
        model_edge(st, sa, stl, br, tgt);
        #1;
        check_all(tag);
    endtask

    function automatic logic [8:0] rnd_word();
        logic [8:0] w;
        w = 9'($urandom_range(0, 510));
        return w;
    endfunction

    initial begin
        logic [9:0] a0;
        for (int i = 0; i < 1024; i++) mem[i] = rnd_word();
        ifc.start_address = '0;
        ifc.stall = 0;
        ifc.branch_taken = 0;
        ifc.branch_target = '0;

        // Straight line from 5
        mem[5] = 9'h012; mem[6] = 9'h034; mem[7] = 9'h1FF;
        step("rst", 1, 7'd5, 0, 0, 10'd0);
        chk("rst.addr5", 16'(ifc.imem_addr), 16'd5);
        step("sl1", 0, 7'd5, 0, 0, 10'd0);
        chk("sl1.instr12", 16'(ifc.instr), 16'h012);
        chk("sl1.pcout5", 16'(ifc.pc_out), 16'd5);
        step("sl2", 0, 7'd5, 0, 0, 10'd0);
        chk("sl2.instr34", 16'(ifc.instr), 16'h034);
        step("sl3", 0, 7'd5, 0, 0, 10'd0);
        chk("sl3.done", 16'(ifc.done), 16'd1);
        chk("sl3.valid0", 16'(ifc.instr_valid), 16'd0);
`ifdef FETCH_CYCLE_COUNT_EN
        chk("sl3.cnt3", ifc.cycle_count, 16'd3);
`endif
        step("hlt1", 0, 7'd5, 1, 1, 10'd40);
        step("hlt2", 0, 7'd5, 0, 1, 10'd41);
        step("hlt3", 0, 7'd5, 0, 0, 10'd0);
        chk("hlt3.done", 16'(ifc.done), 16'd1);

        // Branch under stall at pc=8
        mem[40] = 9'h0AB; mem[41] = 9'h0CD; mem[42] = 9'h0EF;
        step("br0", 1, 7'd8, 0, 0, 10'd0);
        step("br1", 0, 7'd8, 1, 1, 10'd40);
        chk("br1.valid0", 16'(ifc.instr_valid), 16'd0);
        step("br2", 0, 7'd8, 0, 0, 10'd0);
        chk("br2.instr", 16'(ifc.instr), 16'h0AB);
        chk("br2.pcout40", 16'(ifc.pc_out), 16'd40);

        // Stall three edges, then resume at 41
        for (int i = 0; i < 3; i++) begin
            step("stl", 0, 7'd8, 1, 0, 10'd0);
            chk("stl.addr41", 16'(ifc.imem_addr), 16'd41);
            chk("stl.pcout40", 16'(ifc.pc_out), 16'd40);
        end
        step("stl.res", 0, 7'd8, 0, 0, 10'd0);
        chk("stl.res.pcout41", 16'(ifc.pc_out), 16'd41);
        chk("stl.res.instr", 16'(ifc.instr), 16'h0CD);

        // Wrap at 3FF
        mem[10'h3FF] = 9'h055;
        mem[0] = 9'h066;
        step("wr0", 1, 7'd0, 0, 0, 10'd0);
        step("wr1", 0, 7'd0, 0, 1, 10'h3FF);
        step("wr2", 0, 7'd0, 0, 0, 10'd0);
        chk("wr2.pcout3ff", 16'(ifc.pc_out), 16'h3FF);
        chk("wr2.addr0", 16'(ifc.imem_addr), 16'd0);

        // Restart mid-program, then after done
        for (int i = 20; i < 25; i++) mem[i] = rnd_word();
        mem[25] = 9'h1FF;
        step("rs0", 0, 7'd0, 0, 0, 10'd0);
        step("rs1", 1, 7'd20, 0, 0, 10'd0);
        chk("rs1.valid0", 16'(ifc.instr_valid), 16'd0);
        chk("rs1.pcout0", 16'(ifc.pc_out), 16'd0);
        chk("rs1.addr20", 16'(ifc.imem_addr), 16'd20);
        for (int i = 0; i < 6; i++) step("rs.run", 0, 7'd20, 0, 0, 10'd0);
        chk("rs.done", 16'(ifc.done), 16'd1);
        step("rs2", 1, 7'd20, 0, 0, 10'd0);
        chk("rs2.done0", 16'(ifc.done), 16'd0);
        step("rs2b", 1, 7'd20, 0, 0, 10'd0);
        step("rs3", 0, 7'd20, 0, 0, 10'd0);
        chk("rs3.pcout20", 16'(ifc.pc_out), 16'd20);
        chk("rs3.instr", 16'(ifc.instr), 16'(mem[20]));

        // Random phase
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 39) == 0) ? 9'h1FF : rnd_word();
        step("rnd0", 1, 7'($urandom), 0, 0, 10'd0);
        for (int n = 0; n < 3000; n++) begin
            a0 = 10'($urandom);
            step("rnd", ($urandom_range(0, 63) == 0), 7'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), a0);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
